// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage sitting directly in front of the instruction
// memory. Holds the program counter, presents it on IAddr every cycle, picks
// the next PC (PC+4, branch, jump, register jump) and registers the returned
// instruction word for decode. A three-state machine (FETCH / STALLED /
// HALTED) handles stall and halt.
//
// Optional build macro: PC_REDIRECT_COUNT_EN
//   defined   -> RedirectCount counts accepted taken redirects (wraps 2^32)
//   undefined -> RedirectCount is tied to zero, no counter register exists
//
// Ports:
//   CLK            in   1   rising-edge clock
//   Reset          in   1   asynchronous active-high reset
//   Stall          in   1   hold PC and instruction register this cycle
//   PCSrc          in   2   00 PC+4, 01 branch, 10 jump, 11 register jump
//   BranchTaken    in   1   qualifies PCSrc=01 (0 falls back to PC+4)
//   Imm32          in   32  sign-extended branch offset in words
//   JumpTarget     in   26  jump instruction index
//   RegTarget      in   32  rs value for jr
//   IDataIn        in   32  instruction word returned for IAddr
//   IAddr          out  32  current PC (register output only)
//   PCPlus4        out  32  IAddr + 4
//   InsOut         out  32  registered instruction word
//   Halted         out  1   high in HALTED
//   AddrErr        out  1   sticky misaligned-target flag
//   RedirectCount  out  32  taken-redirect counter (see macro above)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0100,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] Imm32,
  input  logic [25:0] JumpTarget,
  input  logic [31:0] RegTarget,
  input  logic [31:0] IDataIn,
  output logic [31:0] IAddr,
  output logic [31:0] PCPlus4,
  output logic [31:0] InsOut,
  output logic        Halted,
  output logic        AddrErr,
  output logic [31:0] RedirectCount
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_STALLED = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [31:0] pc_reg;
  logic [31:0] ins_reg;
  logic        addr_err_reg;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        accept;     // an edge that consumes IDataIn
  logic        halt_hit;   // accepted word carries the halt opcode
  logic        load_pc;    // accepted edge that also advances the PC

  // -------------------------------------------------------------------------
  // Next-PC selection
  // -------------------------------------------------------------------------
  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (PCSrc)
      2'b01:   next_pc = BranchTaken ? (pc_plus4 + (Imm32 << 2)) : pc_plus4;
      2'b10:   next_pc = {pc_plus4[31:28], JumpTarget, 2'b00};
      2'b11:   next_pc = RegTarget;
      default: next_pc = pc_plus4;
    endcase
  end

  // STALLED behaves exactly like FETCH on the edge Stall drops, so both
  // states accept a word whenever Stall is low.
  assign accept   = (state_reg != S_HALTED) && !Stall;
  assign halt_hit = accept && (IDataIn[31:26] == HALT_OPCODE);
  assign load_pc  = accept && !halt_hit;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH, S_STALLED: begin
        if (Stall)         state_next = S_STALLED;
        else if (halt_hit) state_next = S_HALTED;
        else               state_next = S_FETCH;
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    Halted = 1'b0;
    if (state_reg == S_HALTED) Halted = 1'b1;
  end

  // -------------------------------------------------------------------------
  // PC, instruction register and sticky alignment flag
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_reg       <= RESET_PC;
      ins_reg      <= 32'h0;
      addr_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        ins_reg <= IDataIn;
      end
      if (load_pc) begin
        // Misaligned targets are forced down to the word boundary.
        pc_reg <= {next_pc[31:2], 2'b00};
        if (next_pc[1:0] != 2'b00) begin
          addr_err_reg <= 1'b1;
        end
      end
    end
  end

  assign IAddr   = pc_reg;
  assign PCPlus4 = pc_plus4;
  assign InsOut  = ins_reg;
  assign AddrErr = addr_err_reg;

  // -------------------------------------------------------------------------
  // Optional taken-redirect counter
  // -------------------------------------------------------------------------
`ifdef PC_REDIRECT_COUNT_EN
  logic [31:0] redirect_cnt_reg;
  logic        redirect;

  assign redirect = (PCSrc == 2'b10) || (PCSrc == 2'b11) ||
                    ((PCSrc == 2'b01) && BranchTaken);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      redirect_cnt_reg <= 32'h0;
    end else if (load_pc && redirect) begin
      redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
    end
  end

  assign RedirectCount = redirect_cnt_reg;
`else
  assign RedirectCount = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        BranchTaken = 1'b0;
  logic [31:0] Imm32 = 32'h0;
  logic [25:0] JumpTarget = 26'h0;
  logic [31:0] RegTarget = 32'h0;
  logic [31:0] IDataIn = 32'h0;
  logic [31:0] IAddr;
  logic [31:0] PCPlus4;
  logic [31:0] InsOut;
  logic        Halted;
  logic        AddrErr;
  logic [31:0] RedirectCount;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic        m_halt;
  logic        m_err;
  logic [31:0] m_cnt;

  pc_fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc),
    .BranchTaken(BranchTaken), .Imm32(Imm32), .JumpTarget(JumpTarget),
    .RegTarget(RegTarget), .IDataIn(IDataIn), .IAddr(IAddr),
    .PCPlus4(PCPlus4), .InsOut(InsOut), .Halted(Halted),
    .AddrErr(AddrErr), .RedirectCount(RedirectCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_cnt();
`ifdef PC_REDIRECT_COUNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  // Random instruction word guaranteed not to be a halt.
  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'b111111) w[31] = 1'b0;
    return w;
  endfunction

  // Model one rising edge from the architectural rules.
  task automatic model_edge();
    logic [31:0] tgt;
    logic        redir;
    if (m_halt || Stall) return;
    m_ins = IDataIn;
    if (IDataIn[31:26] == 6'b111111) begin
      m_halt = 1'b1;
      return;
    end
    redir = 1'b1;
    if (PCSrc == 2'd3)                        tgt = RegTarget;
    else if (PCSrc == 2'd2)                   tgt = ((m_pc + 4) & 32'hF000_0000) | ({6'd0, JumpTarget} * 4);
    else if (PCSrc == 2'd1 && BranchTaken)    tgt = m_pc + 4 + Imm32 * 4;
    else begin
      tgt   = m_pc + 4;
      redir = 1'b0;
    end
    if (tgt % 4 != 0) m_err = 1'b1;
    m_pc = tgt - (tgt % 4);
    if (redir) m_cnt = m_cnt + 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] src, input logic bt,
                       input logic [31:0] imm, input logic [25:0] jt,
                       input logic [31:0] rt, input logic [31:0] word);
    Stall = st; PCSrc = src; BranchTaken = bt; Imm32 = imm;
    JumpTarget = jt; RegTarget = rt; IDataIn = word;
  endtask

  // Reset asserted and released between clock edges.
  task automatic apply_reset();
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
    m_pc = 32'h100; m_ins = 32'h0; m_halt = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, rand_word());
    #2;
    Reset = 1'b1;
    #1;
    total++;
    if (IAddr !== 32'h100 || InsOut !== 32'h0 || Halted !== 1'b0 ||
        AddrErr !== 1'b0 || RedirectCount !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got addr=%h ins=%h halt=%b err=%b cnt=%h want 00000100/0/0/0/0",
               IAddr, InsOut, Halted, AddrErr, RedirectCount);
    end
    total++;
    if (PCPlus4 !== 32'h104) begin
      bad++;
      $display("FAIL reset_pcplus4: got %h want 00000104", PCPlus4);
    end
    apply_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      w = rand_word();
      drive(1'b0, 2'b00, 1'b0, $urandom, $urandom, $urandom, w);
      step();
      total++;
      if (IAddr !== 32'h104 + 32'(i) * 4 || InsOut !== w) begin
        bad++;
        $display("FAIL seq_fetch[%0d]: got addr=%h ins=%h want addr=%h ins=%h",
                 i, IAddr, InsOut, 32'h104 + 32'(i) * 4, w);
      end
    end
  endtask

  task automatic test_branch();
    apply_reset();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, rand_word());
    step();
    step();
    drive(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFD, 26'h0, 32'h0, rand_word());
    step();
    total++;
    if (IAddr !== 32'h100) begin
      bad++;
      $display("FAIL branch_taken: got %h want 00000100", IAddr);
    end
    total++;
`ifdef PC_REDIRECT_COUNT_EN
    if (RedirectCount !== 32'd1) begin
      bad++;
      $display("FAIL branch_count: got %0d want 1", RedirectCount);
    end
`else
    if (RedirectCount !== 32'd0) begin
      bad++;
      $display("FAIL branch_count: got %0d want 0", RedirectCount);
    end
`endif
    drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, rand_word());
    step();
    step();
    drive(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFD, 26'h0, 32'h0, rand_word());
    step();
    total++;
    if (IAddr !== 32'h10C || RedirectCount !== exp_cnt()) begin
      bad++;
      $display("FAIL branch_not_taken: got addr=%h cnt=%h want 0000010c cnt=%h",
               IAddr, RedirectCount, exp_cnt());
    end
  endtask

  task automatic test_jump();
    apply_reset();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, rand_word());
    step();
    drive(1'b0, 2'b10, 1'b0, 32'h0, 26'h40, 32'h0, rand_word());
    step();
    total++;
    if (IAddr !== 32'h100 || AddrErr !== 1'b0) begin
      bad++;
      $display("FAIL jump: got addr=%h err=%b want 00000100 err=0", IAddr, AddrErr);
    end
    drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'h202, rand_word());
    step();
    total++;
    if (IAddr !== 32'h200 || AddrErr !== 1'b1) begin
      bad++;
      $display("FAIL jr_misaligned: got addr=%h err=%b want 00000200 err=1", IAddr, AddrErr);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, rand_word());
    step();
    step();
    total++;
    if (IAddr !== 32'h208 || AddrErr !== 1'b1) begin
      bad++;
      $display("FAIL addr_err_sticky: got addr=%h err=%b want 00000208 err=1", IAddr, AddrErr);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFC, rand_word());
    step();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, rand_word());
    step();
    total++;
    if (IAddr !== 32'h0 || AddrErr !== 1'b0) begin
      bad++;
      $display("FAIL wrap: got addr=%h err=%b want 00000000 err=0", IAddr, AddrErr);
    end
  endtask

  task automatic test_stall_halt();
    logic [31:0] w_last;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      w_last = rand_word();
      drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, w_last);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i + 1), 1'b1, $urandom, $urandom, $urandom, rand_word());
      step();
      total++;
      if (IAddr !== 32'h10C || InsOut !== w_last) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got addr=%h ins=%h want 0000010c ins=%h",
                 i, IAddr, InsOut, w_last);
      end
    end
    drive(1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 32'hFC00_0000);
    step();
    total++;
    if (Halted !== 1'b0 || InsOut !== w_last) begin
      bad++;
      $display("FAIL stall_beats_halt: got halt=%b ins=%h want halt=0 ins=%h", Halted, InsOut, w_last);
    end
    drive(1'b0, 2'b10, 1'b0, 32'h0, 26'h3FF, 32'h0, 32'hFC00_0000);
    step();
    total++;
    if (Halted !== 1'b1 || IAddr !== 32'h10C || InsOut !== 32'hFC00_0000) begin
      bad++;
      $display("FAIL halt_enter: got halt=%b addr=%h ins=%h want 1 0000010c fc000000",
               Halted, IAddr, InsOut);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, rand_word());
      step();
      total++;
      if (Halted !== 1'b1 || IAddr !== 32'h10C || InsOut !== 32'hFC00_0000 ||
          RedirectCount !== exp_cnt()) begin
        bad++;
        $display("FAIL halt_frozen[%0d]: got halt=%b addr=%h ins=%h cnt=%h",
                 i, Halted, IAddr, InsOut, RedirectCount);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    apply_reset();
    drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'h203, rand_word());
    step();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 32'hFFFF_0000);
    step();
    total++;
    if (Halted !== 1'b1 || AddrErr !== 1'b1 || IAddr !== 32'h200) begin
      bad++;
      $display("FAIL pre_async: got halt=%b err=%b addr=%h want 1 1 00000200", Halted, AddrErr, IAddr);
    end
    #3;
    Reset = 1'b1;
    #1;
    total++;
    if (IAddr !== 32'h100 || InsOut !== 32'h0 || Halted !== 1'b0 || AddrErr !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got addr=%h ins=%h halt=%b err=%b want 00000100/0/0/0",
               IAddr, InsOut, Halted, AddrErr);
    end
    #2;
    Reset = 1'b0;
    m_pc = 32'h100; m_ins = 32'h0; m_halt = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
    w = rand_word();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, w);
    step();
    total++;
    if (IAddr !== 32'h104 || InsOut !== w || Halted !== 1'b0) begin
      bad++;
      $display("FAIL resume_after_reset: got addr=%h ins=%h halt=%b want 00000104 %h 0",
               IAddr, InsOut, Halted, w);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halt && $urandom_range(0, 5) == 0) apply_reset();
      w = $urandom;
      if ($urandom_range(0, 40) == 0) w[31:26] = 6'b111111;
      drive($urandom_range(0, 3) == 0, 2'($urandom), 1'($urandom),
            32'($signed($urandom_range(0, 63)) - 32), $urandom,
            ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC), w);
      step();
      total++;
      if (IAddr !== m_pc || InsOut !== m_ins || Halted !== m_halt ||
          AddrErr !== m_err || RedirectCount !== exp_cnt() || PCPlus4 !== m_pc + 4) begin
        bad++;
        $display("FAIL random[%0d]: got addr=%h ins=%h halt=%b err=%b cnt=%h want addr=%h ins=%h halt=%b err=%b cnt=%h",
                 i, IAddr, InsOut, Halted, AddrErr, RedirectCount,
                 m_pc, m_ins, m_halt, m_err, exp_cnt());
      end
    end
  endtask

  initial begin
    m_pc = 32'h100; m_ins = 32'h0; m_halt = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_stall_halt();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
